// File: rtl/fifo_256i_16o_unpack_if.sv
// rtl/fifo_256i_16o_unpack_if.sv - FIFO read port and pixel stream bundle for the unpacker
//
// Purpose: groups the FIFO read-side signals and the outgoing pixel stream
// of fifo_256i_16o_unpack into one bundle.
// Ports (signals):
//   fifo_rd_en   : read strobe towards the FIFO (driven by master)
//   fifo_rd_data : FIFO read data, valid the cycle after an accepted strobe
//   fifo_empty   : FIFO empty flag
//   out_data     : pixel (driven by master)
//   out_valid    : pixel valid (driven by master)
//   out_ready    : downstream accept
//   out_sol      : pixel 0 of a line, qualified by out_valid
//   out_eol      : last pixel of a line, qualified by out_valid
//   underrun     : one-cycle mid-line starvation pulse
// Modports: master = unpacker side, slave = FIFO/consumer environment side.

interface fifo_256i_16o_unpack_if #(
   parameter int IN_WIDTH  = 256,
   parameter int OUT_WIDTH = 16
);
   logic                 fifo_rd_en;
   logic [IN_WIDTH-1:0]  fifo_rd_data;
   logic                 fifo_empty;
   logic [OUT_WIDTH-1:0] out_data;
   logic                 out_valid;
   logic                 out_ready;
   logic                 out_sol;
   logic                 out_eol;
   logic                 underrun;

   modport master (
      output fifo_rd_en,
      input  fifo_rd_data,
      input  fifo_empty,
      output out_data,
      output out_valid,
      input  out_ready,
      output out_sol,
      output out_eol,
      output underrun
   );

   modport slave (
      input  fifo_rd_en,
      output fifo_rd_data,
      output fifo_empty,
      input  out_data,
      input  out_valid,
      output out_ready,
      input  out_sol,
      input  out_eol,
      input  underrun
   );
endinterface

// File: rtl/fifo_256i_16o_unpack.sv
// rtl/fifo_256i_16o_unpack.sv - unpacks wide FIFO words into a line-marked pixel stream
//
// Purpose: pulls IN_WIDTH-bit words from a standard-mode (1-cycle latency)
// FIFO read port and emits them as LANES pixels of OUT_WIDTH bits on a
// valid/ready stream, one pixel per clock, with start/end-of-line markers.
// Ports:
//   clk : clock, shared with the FIFO read side
//   rst : asynchronous active-high reset
//   bus : fifo_256i_16o_unpack_if.master (FIFO read port + pixel stream)

module fifo_256i_16o_unpack #(
   parameter int IN_WIDTH    = 256,
   parameter int OUT_WIDTH   = 16,
   parameter int LINE_PIXELS = 1024,
   parameter bit LSB_FIRST   = 1'b1
) (
   input  logic                          clk,
   input  logic                          rst,
   fifo_256i_16o_unpack_if.master        bus
);
   localparam int LANES  = IN_WIDTH / OUT_WIDTH;
   localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
   localparam int PIX_W  = (LINE_PIXELS > 1) ? $clog2(LINE_PIXELS) : 1;
   localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);
   localparam logic [PIX_W-1:0]  LAST_PIX  = PIX_W'(LINE_PIXELS - 1);

   logic                 rd_pend_q,  rd_pend_d;
   logic                 pf_valid_q, pf_valid_d;
   logic [IN_WIDTH-1:0]  pf_data_q,  pf_data_d;
   logic [IN_WIDTH-1:0]  sr_q,       sr_d;
   logic                 sr_valid_q, sr_valid_d;
   logic [LANE_W-1:0]    lane_cnt_q, lane_cnt_d;
   logic [PIX_W-1:0]     pix_cnt_q,  pix_cnt_d;
   logic                 underrun_q, underrun_d;

   logic                 rd_en;
   logic                 accept;
   logic                 last_accept;
   logic                 load;
   logic [LANE_W-1:0]    lane_sel;
   logic [OUT_WIDTH-1:0] lanes [LANES];

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      assign lanes[g] = sr_q[g*OUT_WIDTH +: OUT_WIDTH];
   end

   // Lane order is a static choice; MSB-first simply mirrors the counter.
   assign lane_sel = LSB_FIRST ? lane_cnt_q : (LAST_LANE - lane_cnt_q);

   always_comb begin
      // Only one read may be outstanding and the prefetch slot must be free,
      // so a returning word always has somewhere to land. rst forces it low
      // so the FIFO never sees a strobe while both sides are in reset.
      rd_en       = !bus.fifo_empty && !rd_pend_q && !pf_valid_q && !rst;
      accept      = sr_valid_q && bus.out_ready;
      last_accept = accept && (lane_cnt_q == LAST_LANE);
      // Reloading on the same edge as the last lane leaves is what keeps
      // the stream bubble-free across word boundaries.
      load        = pf_valid_q && (!sr_valid_q || last_accept);

      rd_pend_d  = rd_en;

      pf_data_d  = pf_data_q;
      pf_valid_d = pf_valid_q;
      // rd_pend implies pf was empty when the read issued and nothing can
      // fill it in between, so capture and load never coincide.
      if (rd_pend_q) begin
         pf_data_d  = bus.fifo_rd_data;
         pf_valid_d = 1'b1;
      end else if (load) begin
         pf_valid_d = 1'b0;
      end

      sr_d       = sr_q;
      sr_valid_d = sr_valid_q;
      lane_cnt_d = lane_cnt_q;
      if (load) begin
         sr_d       = pf_data_q;
         sr_valid_d = 1'b1;
         lane_cnt_d = '0;
      end else if (last_accept) begin
         sr_valid_d = 1'b0;
         lane_cnt_d = '0;
      end else if (accept) begin
         lane_cnt_d = lane_cnt_q + LANE_W'(1);
      end

      // Line position runs independently of word boundaries.
      pix_cnt_d = pix_cnt_q;
      if (accept) begin
         pix_cnt_d = (pix_cnt_q == LAST_PIX) ? '0 : pix_cnt_q + PIX_W'(1);
      end

      underrun_d = bus.out_ready && !sr_valid_q && (pix_cnt_q != '0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_pend_q  <= 1'b0;
         pf_valid_q <= 1'b0;
         pf_data_q  <= '0;
         sr_q       <= '0;
         sr_valid_q <= 1'b0;
         lane_cnt_q <= '0;
         pix_cnt_q  <= '0;
         underrun_q <= 1'b0;
      end else begin
         rd_pend_q  <= rd_pend_d;
         pf_valid_q <= pf_valid_d;
         pf_data_q  <= pf_data_d;
         sr_q       <= sr_d;
         sr_valid_q <= sr_valid_d;
         lane_cnt_q <= lane_cnt_d;
         pix_cnt_q  <= pix_cnt_d;
         underrun_q <= underrun_d;
      end
   end

   assign bus.fifo_rd_en = rd_en;
   assign bus.out_data   = lanes[lane_sel];
   assign bus.out_valid  = sr_valid_q;
   assign bus.out_sol    = (pix_cnt_q == '0);
   assign bus.out_eol    = (pix_cnt_q == LAST_PIX);
   assign bus.underrun   = underrun_q;

endmodule

// File: tb/tb_fifo_256i_16o_unpack.sv
// tb/tb_fifo_256i_16o_unpack.sv - directed self-checking bench for fifo_256i_16o_unpack

module tb_fifo_256i_16o_unpack;
   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [255:0] rd_data = '0;
   logic         fifo_empty = 1'b1;
   logic         out_ready = 1'b1;

   always #5 clk = ~clk;

   fifo_256i_16o_unpack_if #(.IN_WIDTH(256), .OUT_WIDTH(16)) ifa ();
   fifo_256i_16o_unpack_if #(.IN_WIDTH(256), .OUT_WIDTH(16)) ifb ();

   assign ifa.fifo_rd_data = rd_data;
   assign ifa.fifo_empty   = fifo_empty;
   assign ifa.out_ready    = out_ready;
   assign ifb.fifo_rd_data = rd_data;
   assign ifb.fifo_empty   = fifo_empty;
   assign ifb.out_ready    = out_ready;

   fifo_256i_16o_unpack #(.IN_WIDTH(256), .OUT_WIDTH(16), .LINE_PIXELS(1024), .LSB_FIRST(1'b1))
      dut_a (.clk(clk), .rst(rst), .bus(ifa.master));
   fifo_256i_16o_unpack #(.IN_WIDTH(256), .OUT_WIDTH(16), .LINE_PIXELS(1024), .LSB_FIRST(1'b0))
      dut_b (.clk(clk), .rst(rst), .bus(ifb.master));

   int checks = 0;
   int errors = 0;

   logic [255:0] fq[$];
   logic [15:0]  exp_a[$];
   logic [15:0]  exp_b[$];
   int           tb_pix = 0;
   int           cyc, first_v, last_v, vcnt, rden_cnt, und_cnt, sol_cnt, eol_cnt;
   bit           rand_ready = 1'b0;
   bit           hold = 1'b0;
   logic [17:0]  hold_val = '0;
   bit           first_acc_seen;
   logic [15:0]  first_pix;
   logic         first_sol;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset(input string p);
      chk({p, "_rd_en"},    32'(ifa.fifo_rd_en), 0);
      chk({p, "_valid"},    32'(ifa.out_valid), 0);
      chk({p, "_data"},     32'(ifa.out_data), 0);
      chk({p, "_sol"},      32'(ifa.out_sol), 1);
      chk({p, "_eol"},      32'(ifa.out_eol), 0);
      chk({p, "_underrun"}, 32'(ifa.underrun), 0);
      chk({p, "_valid_b"},  32'(ifb.out_valid), 0);
   endtask

   task automatic clr();
      cyc = 0; first_v = -1; last_v = -1; vcnt = 0; rden_cnt = 0;
      und_cnt = 0; sol_cnt = 0; eol_cnt = 0; first_acc_seen = 1'b0;
   endtask

   task automatic push_word(input logic [15:0] base);
      logic [255:0] w;
      for (int k = 0; k < 16; k++) begin
         w[k*16 +: 16] = base + 16'(k);
         exp_a.push_back(base + 16'(k));
      end
      for (int k = 15; k >= 0; k--) exp_b.push_back(base + 16'(k));
      fq.push_back(w);
      fifo_empty = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      fq.delete();
      fifo_empty = 1'b1;
      exp_a.delete();
      exp_b.delete();
      tb_pix = 0;
      hold = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // One clock: drive, sample at negedge+1, then advance the FIFO model.
   task automatic tick();
      logic s_rd_en;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
      #1;
      s_rd_en = ifa.fifo_rd_en;
      chk("rden_while_empty", 32'(ifa.fifo_rd_en & fifo_empty), 0);
      if (s_rd_en) rden_cnt++;
      if (ifa.underrun) und_cnt++;
      if (ifa.out_valid) begin
         vcnt++;
         if (first_v < 0) first_v = cyc;
         last_v = cyc;
      end
      if (hold && ifa.out_valid)
         chk("stall_stable", 32'({ifa.out_sol, ifa.out_eol, ifa.out_data}), 32'(hold_val));
      hold     = ifa.out_valid && !out_ready;
      hold_val = {ifa.out_sol, ifa.out_eol, ifa.out_data};
      if (ifb.out_valid && out_ready) begin
         if (exp_b.size() == 0) chk("b_unexpected_pixel", exp_b.size(), 1);
         else chk("b_data", 32'(ifb.out_data), 32'(exp_b.pop_front()));
         chk("b_sol", 32'(ifb.out_sol), 32'(tb_pix == 0));
         chk("b_eol", 32'(ifb.out_eol), 32'(tb_pix == 1023));
      end
      if (ifa.out_valid && out_ready) begin
         if (exp_a.size() == 0) chk("a_unexpected_pixel", exp_a.size(), 1);
         else chk("a_data", 32'(ifa.out_data), 32'(exp_a.pop_front()));
         chk("a_sol", 32'(ifa.out_sol), 32'(tb_pix == 0));
         chk("a_eol", 32'(ifa.out_eol), 32'(tb_pix == 1023));
         if (ifa.out_sol) sol_cnt++;
         if (ifa.out_eol) eol_cnt++;
         if (!first_acc_seen) begin
            first_acc_seen = 1'b1;
            first_pix = ifa.out_data;
            first_sol = ifa.out_sol;
         end
         tb_pix = (tb_pix + 1) % 1024;
      end
      @(posedge clk);
      #1;
      if (s_rd_en && fq.size() > 0) rd_data = fq.pop_front();
      fifo_empty = (fq.size() == 0);
      cyc++;
      @(negedge clk);
   endtask

   initial begin
      clr();
      @(posedge clk);
      #1;
      chk_reset("rst0");
      @(negedge clk);
      rst = 1'b0;
      repeat (3) tick();

      // Single word, LSB-first lanes 0x1000..0x100F
      clr();
      push_word(16'h1000);
      repeat (25) tick();
      chk("t1_first_valid", first_v, 3);
      chk("t1_last_valid", last_v, 18);
      chk("t1_rden_pulses", rden_cnt, 1);
      chk("t1_sol_count", sol_cnt, 1);
      chk("t1_drain_a", exp_a.size(), 0);
      chk("t1_drain_b", exp_b.size(), 0);

      // Full 1024-pixel line, both lane orders
      do_reset();
      clr();
      for (int w = 0; w < 64; w++) push_word(16'(w * 16));
      repeat (1040) tick();
      chk("t2_valid_count", vcnt, 1024);
      chk("t2_no_bubbles", last_v - first_v + 1, 1024);
      chk("t2_first_valid", first_v, 3);
      chk("t2_sol_count", sol_cnt, 1);
      chk("t2_eol_count", eol_cnt, 1);
      chk("t2_drain_a", exp_a.size(), 0);
      chk("t3_drain_b", exp_b.size(), 0);
      chk("t2_pix_wrapped", 32'(ifa.out_sol), 1);
      chk("t2_no_underrun", und_cnt, 0);

      // Random back-pressure over 32 words
      clr();
      rand_ready = 1'b1;
      for (int w = 0; w < 32; w++) push_word(16'h4000 + 16'(w * 16));
      for (int n = 0; n < 3000 && exp_a.size() > 0; n++) tick();
      rand_ready = 1'b0;
      out_ready = 1'b1;
      chk("t4_drain_a", exp_a.size(), 0);
      chk("t4_drain_b", exp_b.size(), 0);
      chk("t4_rden_count", rden_cnt, 32);

      // Mid-line starvation after 3 words, then resume at pixel 48
      do_reset();
      clr();
      for (int w = 0; w < 3; w++) push_word(16'h5000 + 16'(w * 16));
      repeat (60) tick();
      chk("t5_underrun_starved", und_cnt, 8);
      chk("t5_drain_first", exp_a.size(), 0);
      first_v = -1;
      push_word(16'h5030);
      push_word(16'h5040);
      repeat (35) tick();
      chk("t5_underrun_total", und_cnt, 12);
      chk("t5_resume_cycle", first_v, 63);
      chk("t5_sol_count", sol_cnt, 1);
      chk("t5_drain_a", exp_a.size(), 0);

      // Reset during word 2, lane 7, with a word still queued in the FIFO
      do_reset();
      clr();
      for (int w = 0; w < 5; w++) push_word(16'h6000 + 16'(w * 16));
      repeat (42) tick();
      chk("t6_pre_lane7", 32'(ifa.out_data), 32'h6027);
      chk("t6_pre_lane7_b", 32'(ifb.out_data), 32'h6028);
      rst = 1'b1;
      #1;
      chk_reset("t6_rst");
      do_reset();
      clr();
      push_word(16'h7000);
      repeat (25) tick();
      chk("t6_first_pixel", 32'(first_pix), 32'h7000);
      chk("t6_first_sol", 32'(first_sol), 1);
      chk("t6_first_valid", first_v, 3);
      chk("t6_drain_a", exp_a.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fifo_256i_16o_unpack.md
# fifo_256i_16o_unpack

Read-side consumer for the 16-bit→256-bit pixel FIFO path. It pulls 256-bit words from a standard-mode (non-show-ahead, 1-cycle read latency) FIFO read port and unpacks each word into sixteen 16-bit pixels. The pixels leave on a valid/ready stream at up to one pixel per clock, with start-of-line and end-of-line markers. It sits between the frame-buffer read FIFO and the display/processing pipeline.

## Interface
- IN_WIDTH, 256: FIFO read-data width. Must be an integer multiple of OUT_WIDTH.
- OUT_WIDTH, 16: pixel width.
- LANES, IN_WIDTH/OUT_WIDTH (16): pixels per word. Derived, not overridden.
- LINE_PIXELS, 1024: pixels per line, used for sol/eol. Must be ≥ 2.
- LSB_FIRST, 1: 1 emits bits [15:0] first; 0 emits bits [IN_WIDTH-1:IN_WIDTH-16] first.

Ports:
- clk, in, 1: single clock, shared with the FIFO read side.
- rst, in, 1: asynchronous, active-high reset.
- fifo_rd_en, out, 1: FIFO read strobe.
- fifo_rd_data, in, IN_WIDTH: FIFO read data, valid the cycle after an accepted fifo_rd_en.
- fifo_empty, in, 1: FIFO empty flag.
- out_data, out, OUT_WIDTH: pixel.
- out_valid, out, 1: pixel valid.
- out_ready, in, 1: downstream accept.
- out_sol, out, 1: out_data is pixel 0 of a line. Qualified by out_valid.
- out_eol, out, 1: out_data is pixel LINE_PIXELS-1. Qualified by out_valid.
- underrun, out, 1: one-cycle pulse, mid-line starvation.

## Operation
The datapath has two stages: a prefetch register (pf_data, pf_valid) and a shift register (sr, lane_cnt 0..LANES-1, sr_valid). A pending-read flag, rd_pend, tracks the outstanding FIFO read.

- fifo_rd_en = !fifo_empty & !rd_pend & !pf_valid. This is combinational from registered state and fifo_empty. It is never asserted while fifo_empty=1.
- A cycle with fifo_rd_en=1 sets rd_pend for exactly the next cycle. In that next cycle, fifo_rd_data is captured into pf_data and pf_valid is set.
- Load condition: pf_valid=1 and (sr_valid=0, or the last lane is accepted this cycle). On load, pf_data→sr, sr_valid=1, lane_cnt=0, pf_valid cleared.
- out_valid = sr_valid.
- out_data = lane lane_cnt of sr. The lane order follows LSB_FIRST.
- Accept = out_valid & out_ready. On accept:
  - If lane_cnt < LANES-1, lane_cnt increments.
  - If lane_cnt = LANES-1, either the next load occurs the same edge, or sr_valid clears.
- pix_cnt (log2(LINE_PIXELS) bits) increments on each accept and wraps LINE_PIXELS-1→0.
  - out_sol = (pix_cnt==0).
  - out_eol = (pix_cnt==LINE_PIXELS-1).
  - Line boundaries are independent of word boundaries. LINE_PIXELS need not be a multiple of LANES.
- underrun = registered (out_ready & !out_valid & pix_cnt!=0). It is asserted the cycle after the condition. pix_cnt is unchanged by an underrun.
- When out_ready=0, out_data, out_sol and out_eol stay stable while out_valid=1.
- Words are never dropped or duplicated. A pixel is emitted only once.

## Timing
- Reset values (rst=1, immediate): fifo_rd_en=0 (forced), out_valid=0, out_data=0, out_sol=1, out_eol=0, underrun=0. Also pf_valid=0, rd_pend=0, sr_valid=0, lane_cnt=0, pix_cnt=0.
- Reset mid-operation discards the prefetch and shift contents, including an in-flight read. The FIFO is reset with the same rst, so no stale word is returned.
- Startup latency, with fifo_empty falling in cycle 0 and out_ready=1:
  - fifo_rd_en=1 in cycle 0.
  - Data is captured at the end of cycle 1.
  - pf→sr at the end of cycle 2.
  - out_valid=1 in cycle 3.
- Steady state: with fifo_empty=0 and out_ready=1, one pixel per clock with no bubbles. The prefetch refills within 3 cycles of being emptied, which is less than LANES.
- Back-pressure: with out_ready=0, at most one FIFO read is issued after pf fills (none once pf_valid=1). Nothing is lost.
- If fifo_empty rises while rd_pend=1, the pending word is still captured.

## Test plan
1. Single word, LSB_FIRST=1: write word with lane k = 16'h1000+k, out_ready=1.
   - out_valid high cycles 3..18.
   - out_data = 0x1000..0x100F.
   - fifo_rd_en pulses once.
   - out_sol on the first pixel.
2. 64 words of consecutive pixels (0x0000..0x03FF), out_ready=1, LINE_PIXELS=1024.
   - 1024 contiguous valid cycles, no bubbles.
   - out_sol on 0x0000, out_eol on 0x03FF.
   - pix_cnt returns to 0.
3. Same stream, LSB_FIRST=0.
   - Each word emitted MSB lane first.
   - Sequence matches reversed lanes.
4. Random out_ready (50%) over 32 words.
   - Output equals the input sequence exactly.
   - out_data stable while stalled.
   - fifo_rd_en never asserted while fifo_empty=1.
5. FIFO drains after 3 words mid-line, out_ready=1.
   - underrun pulses each starved cycle.
   - The line resumes at pixel 48 with no sol.
6. rst asserted during word 2, lane 7.
   - Outputs reach reset values immediately.
   - After release, a refilled FIFO restarts at out_sol with the new first pixel.
